// File: rtl/div_pkg.sv
// Shared widths, FSM encodings and handshake constants for the EX-stage divider.
package div_pkg;

  localparam int REG_BUS        = 32;
  localparam int DOUBLE_REG_BUS = 64;

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  function automatic logic [REG_BUS-1:0] neg(input logic [REG_BUS-1:0] x);
    return ~x + REG_BUS'(1);
  endfunction

  // Magnitude of x when it is a signed negative operand, x unchanged otherwise.
  function automatic logic [REG_BUS-1:0] mag(input logic [REG_BUS-1:0] x, input logic is_signed);
    return (is_signed && x[REG_BUS-1]) ? neg(x) : x;
  endfunction

endpackage

// File: rtl/div_if.sv
// EX <-> divider handshake: operands and start/annul in, {HI,LO} result and ready out.
interface div_if;
  import div_pkg::*;

  logic                      signed_div_i;
  logic [REG_BUS-1:0]        opdata1_i;
  logic [REG_BUS-1:0]        opdata2_i;
  logic                      start_i;
  logic                      annul_i;
  logic [DOUBLE_REG_BUS-1:0] result_o;
  logic                      ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, 34 cycles start to ready.
module div
  import div_pkg::*;
(
  input logic clk,
  input logic rst_n,
  div_if.slave bus
);

  logic [1:0]         state;
  logic [5:0]         cnt;
  logic [64:0]        work;     // {partial remainder, dividend bits shifting into quotient}
  logic [REG_BUS-1:0] divisor;
  logic               neg1, neg2;
  logic [REG_BUS:0]   trial;
  logic [REG_BUS-1:0] q_fix, r_fix;

  assign trial = {1'b0, work[63:32]} - {1'b0, divisor};

  // Quotient negative when signs differ; remainder follows the dividend.
  always_comb begin
    q_fix = (neg1 ^ neg2) ? neg(work[31:0])  : work[31:0];
    r_fix = neg1          ? neg(work[64:33]) : work[64:33];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= DIV_FREE;
      cnt          <= '0;
      work         <= '0;
      divisor      <= '0;
      neg1         <= 1'b0;
      neg2         <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= DIV_RESULT_NOT_READY;
    end else if (state != DIV_FREE && bus.annul_i) begin
      state        <= DIV_FREE;
      cnt          <= '0;
      bus.result_o <= '0;
      bus.ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          bus.result_o <= '0;
          bus.ready_o  <= DIV_RESULT_NOT_READY;
          if (bus.start_i == DIV_START && !bus.annul_i) begin
            neg1    <= bus.signed_div_i & bus.opdata1_i[REG_BUS-1];
            neg2    <= bus.signed_div_i & bus.opdata2_i[REG_BUS-1];
            divisor <= mag(bus.opdata2_i, bus.signed_div_i);
            work    <= {32'b0, mag(bus.opdata1_i, bus.signed_div_i), 1'b0};
            cnt     <= '0;
            state   <= (bus.opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
          end
        end
        DIV_BY_ZERO: begin
          work  <= '0;
          neg1  <= 1'b0;
          neg2  <= 1'b0;
          state <= DIV_END;
        end
        DIV_ON: begin
          if (cnt != 6'd32) begin
            if (trial[REG_BUS]) work <= {work[63:0], 1'b0};
            else                work <= {trial[31:0], work[31:0], 1'b1};
            cnt <= cnt + 6'd1;
          end else begin
            work  <= {r_fix, 1'b0, q_fix};
            cnt   <= '0;
            state <= DIV_END;
          end
        end
        DIV_END: begin
          if (bus.start_i == DIV_STOP) begin
            state        <= DIV_FREE;
            bus.result_o <= '0;
            bus.ready_o  <= DIV_RESULT_NOT_READY;
          end else begin
            bus.result_o <= {work[64:33], work[31:0]};
            bus.ready_o  <= DIV_RESULT_READY;
          end
        end
        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider serving DIV/DIVU in the EX stage. It sits at the originating end of the pipeline stall protocol. While a divide is in flight, EX holds its stall request high, and ctrl drives stall=6'b001111 so that id_ex, if_id and pc hold their contents. The block produces quotient and remainder for HI/LO via a radix-2 restoring shift-subtract loop, one quotient bit per cycle. It can be annulled by a flush.

## Interface
Parameters: none. Widths come from shared macros (`RegBus=32, `DoubleRegBus=64).
- clk  in  1  system clock, all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low (`RstEnable = 1'b0)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend, sampled at start
- opdata2_i  in  32  divisor, sampled at start
- start_i  in  1  `DivStart request from EX; held high until ready_o seen
- annul_i  in  1  cancel in-flight divide (flush or exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}; HI = remainder, LO = quotient
- ready_o  out  1  `DivResultReady while result_o valid

## Operation
- Reset (rst_n low at posedge): state = DivFree, result_o = 0, ready_o = 0, counter = 0.
- DivFree
  - start_i=1 and annul_i=0:
    - Divisor = 0 → DivByZero.
    - Otherwise → DivOn with counter = 0.
    - Operands are latched at this edge.
    - For signed_div_i=1, each negative operand is replaced by its two's complement magnitude.
  - Anything else: stay in DivFree, ready_o = 0, result_o = 0.
- DivByZero: unconditionally → DivEnd with result 0.
- DivOn
  - annul_i=1 has priority over everything else: → DivFree, result_o = 0, ready_o = 0.
  - counter < 32:
    - Form trial = partial remainder minus divisor, 33-bit with borrow.
    - No borrow: remainder = trial, shift in quotient bit 1.
    - Borrow: restore (keep the partial remainder), shift in 0.
    - counter += 1.
  - counter == 32: apply sign fix-up, → DivEnd.
    - Sign fix-up applies only when signed_div_i was 1 at start.
    - Quotient is negated when the operand signs differ.
    - Remainder takes the dividend's sign.
- DivEnd: result_o = final value, ready_o = 1.
  - Stay in DivEnd while start_i stays high.
  - start_i=0 → DivFree, ready_o = 0, result_o = 0.
- Overflow case: 0x80000000 / 0xFFFFFFFF (signed) → quotient 0x80000000, remainder 0. Wraps, no trap.
- Operand changes after the start edge are ignored; signedness is latched at the start edge.

## Timing
- Cycle 0: start_i seen in DivFree.
- Cycles 1–32: iterations.
- Cycle 33: fix-up.
- Cycle 34: ready_o = 1 (34-cycle latency from start to ready).
- Divide-by-zero: ready_o = 1 in cycle 2.
- ready_o and result_o change only at posedge and are registered, so there is no combinational path from inputs.
- Annul takes effect at the next posedge from any state except DivFree.
  - DivByZero and DivEnd also return to DivFree on annul.
  - Annul wins over start_i in the same cycle.
- Back-to-back divides: EX must drop start_i for at least one cycle (DivEnd → DivFree) before the next start is accepted.
- rst_n low mid-operation aborts immediately at the next edge, with no result.

## Structure
- Add to macro.v:
  - `DivFree 2'b00, `DivByZero 2'b01, `DivOn 2'b10, `DivEnd 2'b11
  - `DivResultReady 1'b1, `DivResultNotReady 1'b0
  - `DivStart 1'b1, `DivStop 1'b0
- Single module with a 2-bit state register, 6-bit counter, 65-bit working register ({remainder, dividend/quotient}), 32-bit divisor register, and latched sign flags.
- No sub-module. The 33-bit trial subtractor stays inline.
- The EX-side integration (start/stallreq generation from ready_o) lives in ex.v, not here.

## Test plan
- DIVU 100 / 7 → ready_o in cycle 34, result_o = {0x00000002, 0x0000000E}.
- DIV −7 / 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0, no hang.
- Divisor 0 (either signedness) → ready_o = 1 in cycle 2, result_o = 0.
- annul_i pulsed in cycle 10 of DIVU 0xFFFFFFFF / 3 → state DivFree and ready_o = 0 next cycle. A new DIVU 9 / 3 started afterwards returns {0, 3} with full latency.
- Hold start_i for 5 cycles after ready → ready_o and result_o stable. Drop start_i → ready_o = 0 next cycle. Assert rst_n=0 mid-divide → all outputs 0 at the next edge.
